// File: rtl/div_request_scheduler.sv
// Valid/ready front end for a fixed-latency signed 32-bit divider: issue registers, latency-matched
// tag tracker, credit-guarded result FIFO. Optional macro DIV_ZERO_SAT_EN saturates divide-by-zero.
module div_request_scheduler #(
   parameter int unsigned LATENCY = 36,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned TAG_W   = 8
) (
   input  logic             aclk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_dividend,
   input  logic [31:0]      req_divisor,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      div_dividend_tdata,
   output logic             div_dividend_tvalid,
   output logic [31:0]      div_divisor_tdata,
   output logic             div_divisor_tvalid,
   input  logic [63:0]      div_dout_tdata,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_quotient,
   output logic [31:0]      res_fraction,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_div_zero,
   output logic             busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TOT_W = CNT_W + 1;
   localparam int unsigned LAST  = LATENCY - 1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
`ifdef DIV_ZERO_SAT_EN
      logic             div_zero;
      logic             neg;
`endif
   } trk_t;

   typedef struct packed {
      logic [31:0]      quotient;
      logic [31:0]      fraction;
      logic [TAG_W-1:0] tag;
`ifdef DIV_ZERO_SAT_EN
      logic             div_zero;
`endif
   } res_t;

   trk_t             issue_q;
   trk_t             trk [LATENCY];
   trk_t             trk_last;

   logic             accept;
   logic             capture;
   logic             pop;

   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] inflight_nxt;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] fifo_count_nxt;
   logic [TOT_W-1:0] total;

   res_t             cap_entry;
   res_t             mem [DEPTH];
   res_t             head;
   logic             head_vld;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] mem_count;
   logic             head_load;
   logic             mem_rd;
   logic             mem_wr;

   // Credits: every accepted request owns a FIFO slot until it is popped.
   assign total     = TOT_W'(inflight) + TOT_W'(fifo_count);
   assign req_ready = !rst && (total < TOT_W'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign trk_last  = trk[LAST];
   assign capture   = trk_last.valid;
   assign pop       = head_vld && res_ready;

   assign div_dividend_tvalid = issue_q.valid;
   assign div_divisor_tvalid  = issue_q.valid;

   // Issue registers; the tag rides alongside the divider operands.
   always_ff @(posedge aclk) begin
      if (rst) begin
         issue_q            <= '0;
         div_dividend_tdata <= '0;
         div_divisor_tdata  <= '0;
      end else begin
         issue_q.valid <= accept;
         if (accept) begin
            issue_q.tag        <= req_tag;
            div_dividend_tdata <= req_dividend;
            div_divisor_tdata  <= req_divisor;
`ifdef DIV_ZERO_SAT_EN
            issue_q.div_zero   <= (req_divisor == 32'd0);
            issue_q.neg        <= req_dividend[31];
`endif
         end
      end
   end

   // Tracker: the last stage lines up with div_dout_tdata for the same operation.
   always_ff @(posedge aclk) begin
      if (rst) begin
         for (int i = 0; i < int'(LATENCY); i++) trk[i] <= '0;
      end else begin
         trk[0] <= issue_q;
         for (int i = 1; i < int'(LATENCY); i++) trk[i] <= trk[i-1];
      end
   end

   always_comb begin
      cap_entry.quotient = div_dout_tdata[63:32];
      cap_entry.fraction = div_dout_tdata[31:0];
      cap_entry.tag      = trk_last.tag;
`ifdef DIV_ZERO_SAT_EN
      cap_entry.div_zero = trk_last.div_zero;
      if (trk_last.div_zero) begin
         cap_entry.quotient = trk_last.neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
         cap_entry.fraction = '0;
      end
`endif
   end

   // The head register is the oldest entry; mem holds the ones queued behind it.
   always_comb begin
      head_load = !head_vld || pop;
      mem_rd    = head_load && (mem_count != '0);
      mem_wr    = capture && !(head_load && (mem_count == '0));
   end

   always_ff @(posedge aclk) begin
      if (mem_wr) mem[wr_ptr] <= cap_entry;
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         head_vld  <= 1'b0;
         head      <= '0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (mem_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         mem_count <= mem_count + CNT_W'(mem_wr) - CNT_W'(mem_rd);
         if (head_load) begin
            if (mem_rd) head <= mem[rd_ptr];
            else if (capture) head <= cap_entry;
            head_vld <= mem_rd || capture;
         end
      end
   end

   assign fifo_count     = mem_count + CNT_W'(head_vld);
   assign inflight_nxt   = inflight + CNT_W'(accept) - CNT_W'(capture);
   assign fifo_count_nxt = fifo_count + CNT_W'(capture) - CNT_W'(pop);

   always_ff @(posedge aclk) begin
      if (rst) begin
         inflight <= '0;
         busy     <= 1'b0;
      end else begin
         inflight <= inflight_nxt;
         busy     <= (inflight_nxt != '0) || (fifo_count_nxt != '0);
      end
   end

   assign res_valid    = head_vld;
   assign res_quotient = head.quotient;
   assign res_fraction = head.fraction;
   assign res_tag      = head.tag;
`ifdef DIV_ZERO_SAT_EN
   assign res_div_zero = head.div_zero;
`else
   assign res_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_request_scheduler.sv
// Bench for div_request_scheduler: behavioural divider stand-in, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_div_request_scheduler;

   localparam int unsigned LATENCY = 36;
   localparam int unsigned DEPTH   = 64;
   localparam int unsigned TAG_W   = 8;

   logic             aclk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_dividend;
   logic [31:0]      req_divisor;
   logic [TAG_W-1:0] req_tag;
   logic [31:0]      div_dividend_tdata;
   logic             div_dividend_tvalid;
   logic [31:0]      div_divisor_tdata;
   logic             div_divisor_tvalid;
   logic [63:0]      div_dout_tdata;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_quotient;
   logic [31:0]      res_fraction;
   logic [TAG_W-1:0] res_tag;
   logic             res_div_zero;
   logic             busy;

   always #5 aclk = ~aclk;

   div_request_scheduler #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .aclk(aclk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
      .div_dividend_tdata(div_dividend_tdata), .div_dividend_tvalid(div_dividend_tvalid),
      .div_divisor_tdata(div_divisor_tdata), .div_divisor_tvalid(div_divisor_tvalid),
      .div_dout_tdata(div_dout_tdata),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_quotient(res_quotient), .res_fraction(res_fraction),
      .res_tag(res_tag), .res_div_zero(res_div_zero), .busy(busy)
   );

   // Divider stand-in: ignores tvalid, output appears LATENCY cycles after the inputs.
   logic [63:0] dpipe [LATENCY];

   function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 64'hDEAD_BEEF_0BAD_F00D;
      return {32'(longint'($signed(a)) / longint'($signed(b))), 32'h0};
   endfunction

   always @(posedge aclk) begin
      dpipe[0] <= div_fn(div_dividend_tdata, div_divisor_tdata);
      for (int i = 1; i < int'(LATENCY); i++) dpipe[i] <= dpipe[i-1];
   end
   assign div_dout_tdata = dpipe[LATENCY-1];

   int n_vec  = 0;
   int n_fail = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endfunction

   // Reference model: ordered queue of expected results, each with the edge it becomes visible.
   typedef struct {
      logic [31:0]      q;
      logic [31:0]      f;
      logic [TAG_W-1:0] tag;
      logic             z;
      int               avail;
   } exp_t;

   exp_t        sb[$];
   int          edge_n = 0;
   int          n_acc  = 0;
   int          n_pop  = 0;
   bit          armed  = 0;
   logic        exp_tv = 1'b0;
   logic [31:0] exp_a  = '0;
   logic [31:0] exp_b  = '0;

   function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [TAG_W-1:0] t, input int av);
      exp_t e;
      e.tag   = t;
      e.avail = av;
      e.f     = 32'h0;
      e.z     = 1'b0;
`ifdef DIV_ZERO_SAT_EN
      if (b == 32'd0) begin
         e.q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         e.z = 1'b1;
         return e;
      end
`endif
      e.q = 32'(longint'($signed(a)) / longint'($signed(b)));
      return e;
   endfunction

   initial forever begin
      bit mv;
      bit mr;
      @(posedge aclk);
      mv = (sb.size() > 0) && (sb[0].avail <= edge_n);
      mr = !rst && (sb.size() < int'(DEPTH));
      edge_n++;
      if (rst) begin
         sb.delete();
         exp_tv = 1'b0;
         exp_a  = '0;
         exp_b  = '0;
         armed  = 1;
      end else begin
         if (mv && res_ready) begin
            void'(sb.pop_front());
            n_pop++;
         end
         exp_tv = 1'b0;
         if (req_valid && mr) begin
            sb.push_back(mk_exp(req_dividend, req_divisor, req_tag, edge_n + int'(LATENCY) + 1));
            exp_tv = 1'b1;
            exp_a  = req_dividend;
            exp_b  = req_divisor;
            n_acc++;
         end
      end
   end

   // Per-cycle compare against the model.
   initial forever begin
      bit mv;
      @(negedge aclk);
      if (armed) begin
         mv = (sb.size() > 0) && (sb[0].avail <= edge_n);
         chk("req_ready", 64'(req_ready), 64'(!rst && (sb.size() < int'(DEPTH))));
         chk("res_valid", 64'(res_valid), 64'(mv));
         chk("busy", 64'(busy), 64'(sb.size() != 0));
         chk("dividend_tvalid", 64'(div_dividend_tvalid), 64'(exp_tv));
         chk("divisor_tvalid", 64'(div_divisor_tvalid), 64'(exp_tv));
         chk("dividend_tdata", 64'(div_dividend_tdata), 64'(exp_a));
         chk("divisor_tdata", 64'(div_divisor_tdata), 64'(exp_b));
         if (mv) begin
            chk("res_quotient", 64'(res_quotient), 64'(sb[0].q));
            chk("res_fraction", 64'(res_fraction), 64'(sb[0].f));
            chk("res_tag", 64'(res_tag), 64'(sb[0].tag));
            chk("res_div_zero", 64'(res_div_zero), 64'(sb[0].z));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
      req_valid    = v;
      req_dividend = a;
      req_divisor  = b;
      req_tag      = t;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic wait_res(input string name);
      for (int i = 0; i < 200 && !res_valid; i++) begin
         @(posedge aclk);
         #1;
      end
      if (!res_valid) chk({name, "_timeout"}, 64'(res_valid), 64'(1'b1));
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 400 && busy; i++) begin
         @(posedge aclk);
         #1;
      end
      chk({name, "_drained"}, 64'(busy), 64'(1'b0));
   endtask

   initial begin
      int a0;
      int p0;
      int acc_edge;
      int stale;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_dividend = '0;
      req_divisor  = '0;
      req_tag      = '0;
      res_ready    = 1'b1;
      repeat (3) @(posedge aclk);
      #1;

      chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
      chk("rst_tvalid", 64'(div_dividend_tvalid), 64'(1'b0));
      chk("rst_tdata", 64'(div_divisor_tdata), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
      chk("rst_res_quotient", 64'(res_quotient), 64'(0));
      chk("rst_res_tag", 64'(res_tag), 64'(0));
      chk("rst_busy", 64'(busy), 64'(1'b0));
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(req_ready), 64'(1'b1));
      idle(1);

      // Single request
      drive(1'b1, 32'd100, 32'd7, 8'h5A);
      acc_edge = edge_n;
      req_valid = 1'b0;
      wait_res("single");
      chk("single_latency", 64'(edge_n - acc_edge), 64'(37));
      chk("single_quotient", 64'(res_quotient), 64'(14));
      chk("single_tag", 64'(res_tag), 64'(8'h5A));
      chk("single_fraction", 64'(res_fraction), 64'(0));
      drain("single");

      // Back-to-back
      a0 = n_acc;
      p0 = n_pop;
      for (int i = 0; i < 40; i++) begin
         chk("b2b_ready", 64'(req_ready), 64'(1'b1));
         drive(1'b1, 32'(i * 3), 32'd3, 8'(i));
      end
      idle(1);
      drain("b2b");
      chk("b2b_accepts", 64'(n_acc - a0), 64'(40));
      chk("b2b_pops", 64'(n_pop - p0), 64'(40));

      // Signed corner cases
      drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'hC3);
      idle(1);
      wait_res("intmin");
      chk("intmin_quotient", 64'(res_quotient), 64'(32'h8000_0000));
      chk("intmin_flag", 64'(res_div_zero), 64'(1'b0));
      idle(1);
`ifdef DIV_ZERO_SAT_EN
      drive(1'b1, 32'hFFFF_FFFB, 32'd0, 8'h10);
      drive(1'b1, 32'd9, 32'd0, 8'h11);
`endif
      drive(1'b1, 32'hFFFF_FFF7, 32'd2, 8'h12);
      idle(1);
`ifdef DIV_ZERO_SAT_EN
      wait_res("dz_neg");
      chk("dz_neg_quotient", 64'(res_quotient), 64'(32'h8000_0000));
      chk("dz_neg_flag", 64'(res_div_zero), 64'(1'b1));
      idle(1);
      wait_res("dz_pos");
      chk("dz_pos_quotient", 64'(res_quotient), 64'(32'h7FFF_FFFF));
      chk("dz_pos_flag", 64'(res_div_zero), 64'(1'b1));
      idle(1);
`endif
      wait_res("neg9");
      chk("neg9_quotient", 64'(res_quotient), 64'(32'hFFFF_FFFC));
      chk("neg9_flag", 64'(res_div_zero), 64'(1'b0));
      drain("corner");

      // Backpressure fills every credit
      res_ready = 1'b0;
      a0 = n_acc;
      p0 = n_pop;
      for (int i = 0; i < 70; i++) drive(1'b1, 32'(i * 5 + 1), 32'((i % 7) + 1), 8'(i));
      idle(1);
      chk("bp_accepts", 64'(n_acc - a0), 64'(64));
      chk("bp_ready_low", 64'(req_ready), 64'(1'b0));
      idle(int'(LATENCY) + 4);
      chk("bp_full_valid", 64'(res_valid), 64'(1'b1));
      chk("bp_full_ready", 64'(req_ready), 64'(1'b0));
      res_ready = 1'b1;
      @(posedge aclk);
      #1;
      res_ready = 1'b0;
      chk("bp_ready_back", 64'(req_ready), 64'(1'b1));

      // Accept and pop together with 63 held
      chk("sim_pre_count", 64'(sb.size()), 64'(63));
      res_ready = 1'b1;
      drive(1'b1, 32'd77, 32'd11, 8'hEE);
      req_valid = 1'b0;
      res_ready = 1'b0;
      chk("sim_count", 64'(sb.size()), 64'(63));
      chk("sim_ready", 64'(req_ready), 64'(1'b1));
      res_ready = 1'b1;
      drain("bp");
      chk("bp_pops", 64'(n_pop - p0), 64'(65));

      // Mid-flight reset
      for (int i = 0; i < 10; i++) drive(1'b1, 32'(1000 + i), 32'd10, 8'(8'h80 + i));
      idle(10);
      rst = 1'b1;
      @(posedge aclk);
      #1;
      rst = 1'b0;
      chk("mrst_res_valid", 64'(res_valid), 64'(1'b0));
      chk("mrst_busy", 64'(busy), 64'(1'b0));
      chk("mrst_tvalid", 64'(div_divisor_tvalid), 64'(1'b0));
      chk("mrst_tdata", 64'(div_dividend_tdata), 64'(0));
      chk("mrst_quotient", 64'(res_quotient), 64'(0));
      chk("mrst_tag", 64'(res_tag), 64'(0));
      stale = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge aclk);
         #1;
         if (res_valid) stale++;
      end
      chk("mrst_no_stale", 64'(stale), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_fail);
      $fatal(1);
   end

endmodule
